// File: rtl/read_req_arbiter.sv
// Round-robin scheduler sharing one memory read-address channel; splits requests into bursts
// and pushes one read-info entry per issued burst. Optional build macro: RD_ARB_SPLIT_4K_EN.
module read_req_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned RD_SIZE_W  = 20,
  parameter int unsigned D_TYPE_W   = 2,
  parameter int unsigned PU_ID_W    = 2,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned BEAT_BYTES = 64,
  localparam int unsigned GID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*RD_SIZE_W-1:0]  req_size,
  input  logic [NUM_REQ*PU_ID_W-1:0]    req_pu_id,
  input  logic [NUM_REQ*D_TYPE_W-1:0]   req_d_type,
  output logic                          mem_rd_req,
  input  logic                          mem_rd_ready,
  output logic [ADDR_W-1:0]             mem_rd_addr,
  output logic [7:0]                    mem_rd_len,
  output logic                          rd_req,
  output logic [RD_SIZE_W-1:0]          rd_req_size,
  output logic [PU_ID_W-1:0]            rd_req_pu_id,
  output logic [D_TYPE_W-1:0]           rd_req_d_type,
  input  logic                          read_info_full,
  output logic                          busy,
  output logic [GID_W-1:0]              grant_id
);

  localparam int unsigned LEN_W = $clog2(MAX_BURST) + 1;
  localparam int unsigned BB_SH = $clog2(BEAT_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_REQ} state_t;
  state_t r_state, w_state_nxt;

  logic [GID_W-1:0]     r_rr_ptr, r_grant, w_gnt;
  logic [GID_W:0]       w_idx;
  logic                 w_gnt_vld;
  logic [ADDR_W-1:0]    r_addr, r_mem_addr;
  logic [RD_SIZE_W-1:0] r_remaining;
  logic [PU_ID_W-1:0]   r_pu_id;
  logic [D_TYPE_W-1:0]  r_d_type;
  logic                 r_mem_req;
  logic [7:0]           r_mem_len;
  logic [LEN_W-1:0]     w_len;
  logic                 w_issue, w_hs;
`ifdef RD_ARB_SPLIT_4K_EN
  logic [12:0]          w_room;
`endif

  // Cyclic search for the first valid channel at or after the round-robin pointer.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (GID_W+1)'(k);
      if (w_idx >= (GID_W+1)'(NUM_REQ)) w_idx = w_idx - (GID_W+1)'(NUM_REQ);
      if (!w_gnt_vld && req_valid[w_idx[GID_W-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_idx[GID_W-1:0];
      end
    end
  end

  always_comb begin
    w_len = LEN_W'(MAX_BURST);
    if (r_remaining < RD_SIZE_W'(MAX_BURST)) w_len = r_remaining[LEN_W-1:0];
`ifdef RD_ARB_SPLIT_4K_EN
    w_room = (13'd4096 - {1'b0, r_addr[11:0]}) >> BB_SH;
    if ({{(13-LEN_W){1'b0}}, w_len} > w_room) w_len = w_room[LEN_W-1:0];
`endif
  end

  assign w_hs = r_mem_req & mem_rd_ready;

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: if (w_gnt_vld) begin
        req_ready[w_gnt] = 1'b1;
        w_state_nxt      = S_CALC;
      end
      S_CALC: if (r_remaining == '0) begin
        w_state_nxt = S_IDLE;
      end else if (!read_info_full) begin
        w_issue     = 1'b1;
        w_state_nxt = S_REQ;
      end
      S_REQ:   if (w_hs) w_state_nxt = S_CALC;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_pu_id     <= '0;
      r_d_type    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_len   <= '0;
    end else begin
      if (r_state == S_IDLE && w_gnt_vld) begin
        r_addr      <= req_addr[w_gnt*ADDR_W +: ADDR_W];
        r_remaining <= req_size[w_gnt*RD_SIZE_W +: RD_SIZE_W];
        r_pu_id     <= req_pu_id[w_gnt*PU_ID_W +: PU_ID_W];
        r_d_type    <= req_d_type[w_gnt*D_TYPE_W +: D_TYPE_W];
        r_grant     <= w_gnt;
        r_rr_ptr    <= (w_gnt == GID_W'(NUM_REQ-1)) ? '0 : w_gnt + 1'b1;
      end
      if (w_issue) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= r_addr;
        r_mem_len  <= 8'(w_len - 1'b1);
      end
      // r_addr/r_remaining are frozen while in REQ, so w_len still equals the issued length.
      if (w_hs) begin
        r_mem_req   <= 1'b0;
        r_addr      <= r_addr + (ADDR_W'(w_len) << BB_SH);
        r_remaining <= r_remaining - RD_SIZE_W'(w_len);
      end
    end
  end

  assign mem_rd_req    = r_mem_req;
  assign mem_rd_addr   = r_mem_addr;
  assign mem_rd_len    = r_mem_len;
  assign rd_req        = w_hs;
  assign rd_req_size   = RD_SIZE_W'(r_mem_len);
  assign rd_req_pu_id  = r_pu_id;
  assign rd_req_d_type = r_d_type;
  assign busy          = (r_state != S_IDLE);
  assign grant_id      = r_grant;

endmodule

// File: tb/tb_read_req_arbiter.sv
// Randomized self-checking bench for read_req_arbiter against a burst-queue reference model.
`timescale 1ns/1ps
module tb_read_req_arbiter;
  localparam int N = 3, AW = 32, SW = 20, DW = 2, PW = 2, MB = 16, BB = 64;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*SW-1:0] req_size;
  logic [N*PW-1:0] req_pu_id;
  logic [N*DW-1:0] req_d_type;
  logic            mem_rd_req, mem_rd_ready, rd_req, read_info_full, busy;
  logic [AW-1:0]   mem_rd_addr;
  logic [7:0]      mem_rd_len;
  logic [SW-1:0]   rd_req_size;
  logic [PW-1:0]   rd_req_pu_id;
  logic [DW-1:0]   rd_req_d_type;
  logic [1:0]      grant_id;

  logic [AW-1:0] a_addr [N];
  logic [SW-1:0] a_size [N];
  logic [PW-1:0] a_pu   [N];
  logic [DW-1:0] a_dt   [N];

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign req_addr[i*AW +: AW]   = a_addr[i];
    assign req_size[i*SW +: SW]   = a_size[i];
    assign req_pu_id[i*PW +: PW]  = a_pu[i];
    assign req_d_type[i*DW +: DW] = a_dt[i];
  end

  read_req_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .RD_SIZE_W(SW), .D_TYPE_W(DW),
    .PU_ID_W(PW), .MAX_BURST(MB), .BEAT_BYTES(BB)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_pu_id(req_pu_id), .req_d_type(req_d_type),
    .mem_rd_req(mem_rd_req), .mem_rd_ready(mem_rd_ready),
    .mem_rd_addr(mem_rd_addr), .mem_rd_len(mem_rd_len),
    .rd_req(rd_req), .rd_req_size(rd_req_size), .rd_req_pu_id(rd_req_pu_id),
    .rd_req_d_type(rd_req_d_type), .read_info_full(read_info_full),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the accepted request becomes a queue of bursts computed arithmetically.
  typedef struct {logic [AW-1:0] addr; int unsigned len;} burst_t;
  typedef struct {logic [AW-1:0] addr; int unsigned len; int unsigned size;} hs_t;
  burst_t      m_q[$];
  hs_t         hs_log[$];
  int unsigned gnt_log[$];
  bit          m_busy, m_calc, post_reset;
  int unsigned m_rr, m_gid, memreq_cnt;
  logic [PW-1:0] m_pu;
  logic [DW-1:0] m_dt;
  int unsigned acc_cnt [N];

  function automatic void split(input logic [AW-1:0] a, input int unsigned s);
    int unsigned l;
    burst_t b;
    while (s > 0) begin
      l = (s < MB) ? s : MB;
`ifdef RD_ARB_SPLIT_4K_EN
      if ((4096 - (a % 4096)) / BB < l) l = (4096 - (a % 4096)) / BB;
`endif
      b.addr = a;
      b.len  = l;
      m_q.push_back(b);
      a = a + AW'(l * BB);
      s -= l;
    end
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      m_q.delete();
      m_busy = 0; m_calc = 0; m_rr = 0; m_gid = 0; post_reset = 1;
    end else begin
      int g;
      hs_t h;
      if (post_reset) begin
        check("rst_addr", mem_rd_addr, 0);
        check("rst_len", mem_rd_len, 0);
        check("rst_rdsize", rd_req_size, 0);
        check("rst_pu", rd_req_pu_id, 0);
        check("rst_dt", rd_req_d_type, 0);
        post_reset = 0;
      end
      check("busy", busy, m_busy);
      check("grant_id", grant_id, m_gid);
      if (mem_rd_req) memreq_cnt++;
      if (!m_busy) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(int'(m_rr) + k) % N]) g = (int'(m_rr) + k) % N;
        check("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
        check("mem_rd_req_idle", mem_rd_req, 0);
        check("rd_req_idle", rd_req, 0);
        if (g >= 0) begin
          acc_cnt[g]++;
          gnt_log.push_back(g);
          m_gid = g; m_rr = (g + 1) % N;
          m_pu = a_pu[g]; m_dt = a_dt[g];
          split(a_addr[g], a_size[g]);
          m_busy = 1; m_calc = 1;
        end
      end else if (m_calc) begin
        check("req_ready_busy", req_ready, 0);
        check("mem_rd_req_calc", mem_rd_req, 0);
        check("rd_req_calc", rd_req, 0);
        if (m_q.size() == 0) m_busy = 0;
        else if (!read_info_full) m_calc = 0;
      end else begin
        check("req_ready_busy", req_ready, 0);
        check("mem_rd_req", mem_rd_req, 1);
        check("mem_rd_addr", mem_rd_addr, m_q[0].addr);
        check("mem_rd_len", mem_rd_len, m_q[0].len - 1);
        check("rd_req", rd_req, mem_rd_ready);
        if (mem_rd_ready) begin
          check("rd_req_size", rd_req_size, m_q[0].len - 1);
          check("rd_req_pu_id", rd_req_pu_id, m_pu);
          check("rd_req_d_type", rd_req_d_type, m_dt);
          h.addr = mem_rd_addr; h.len = mem_rd_len; h.size = rd_req_size;
          hs_log.push_back(h);
          void'(m_q.pop_front());
          m_calc = 1;
        end
      end
    end
  end

  // Driver: requests stay stable until accepted; acceptance is tracked via acc_cnt.
  bit rand_mode = 0;
  int unsigned seen [N];

  task automatic new_req(input int i);
    a_addr[i]    = ($urandom & 32'hFFFF_F000) | (AW'($urandom_range(0, 63)) << 6);
    a_size[i]    = ($urandom % 8 == 0) ? '0 : SW'($urandom_range(1, 70));
    a_pu[i]      = PW'($urandom);
    a_dt[i]      = DW'($urandom_range(0, 2));
    req_valid[i] = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input int unsigned s,
                         input int unsigned pu, input int unsigned dt);
    a_addr[i] = a; a_size[i] = SW'(s); a_pu[i] = PW'(pu); a_dt[i] = DW'(dt);
    req_valid[i] = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (acc_cnt[i] != seen[i]) begin
        seen[i] = acc_cnt[i];
        if (rand_mode && $urandom % 3 != 0) new_req(i);
        else req_valid[i] = 1'b0;
      end else if (rand_mode && !req_valid[i] && $urandom % 5 == 0) begin
        new_req(i);
      end
    end
    if (rand_mode) begin
      mem_rd_ready = ($urandom % 3 != 0);
      if (!mem_rd_req) read_info_full = ($urandom % 4 == 0);
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b, m0;
    reset = 1'b1; req_valid = '0; mem_rd_ready = 1'b0; read_info_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_addr[i] = '0; a_size[i] = '0; a_pu[i] = '0; a_dt[i] = '0; seen[i] = 0; acc_cnt[i] = 0;
    end
    memreq_cnt = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Round-robin: all three valid twice -> 0,1,2,0,1,2
    mem_rd_ready = 1'b1;
    b = gnt_log.size();
    repeat (2) begin
      for (int i = 0; i < N; i++) set_req(i, 32'h4000 + 32'(i * 64), 1, i, 0);
      run(15);
    end
    check("rr_count", gnt_log.size() - b, 6);
    for (int k = 0; k < 6; k++)
      check("rr_order", (b + k < gnt_log.size()) ? gnt_log[b + k] : 99, k % 3);

    // Single request: 40 beats from 0x1000
    b = hs_log.size();
    set_req(0, 32'h1000, 40, 1, 1);
    run(20);
    check("single_bursts", hs_log.size() - b, 3);
    if (hs_log.size() - b == 3) begin
      check("single_a0", hs_log[b].addr, 32'h1000);
      check("single_a1", hs_log[b+1].addr, 32'h1400);
      check("single_a2", hs_log[b+2].addr, 32'h1800);
      check("single_l0", hs_log[b].len, 15);
      check("single_l2", hs_log[b+2].len, 7);
      check("single_s1", hs_log[b+1].size, 15);
      check("single_s2", hs_log[b+2].size, 7);
    end

    // Back-pressure: read-info full, then memory not ready
    read_info_full = 1'b1;
    m0 = memreq_cnt;
    set_req(2, 32'h2000, 20, 2, 2);
    run(12);
    check("bp_full_noreq", memreq_cnt - m0, 0);
    check("bp_full_busy", busy, 1);
    read_info_full = 1'b0;
    mem_rd_ready = 1'b0;
    step();
    check("bp_release", mem_rd_req, 1);
    run(5);
    check("bp_hold_req", mem_rd_req, 1);
    check("bp_hold_addr", mem_rd_addr, 32'h2000);
    check("bp_hold_len", mem_rd_len, 15);
    check("bp_hold_rdreq", rd_req, 0);
    mem_rd_ready = 1'b1;
    run(10);

    // Zero size on ch1
    b = hs_log.size(); m0 = memreq_cnt;
    set_req(1, 32'h40, 0, 3, 1);
    step();
    check("zero_busy1", busy, 1);
    step();
    check("zero_idle", busy, 0);
    check("zero_grant", gnt_log[gnt_log.size() - 1], 1);
    check("zero_noreq", memreq_cnt - m0, 0);
    check("zero_nopush", hs_log.size() - b, 0);

    // 4 KiB boundary
    b = hs_log.size();
    set_req(0, 32'h0FC0, 4, 0, 0);
    run(12);
`ifdef RD_ARB_SPLIT_4K_EN
    check("split_count", hs_log.size() - b, 2);
    if (hs_log.size() - b == 2) begin
      check("split_a0", hs_log[b].addr, 32'h0FC0);
      check("split_l0", hs_log[b].len, 0);
      check("split_a1", hs_log[b+1].addr, 32'h1000);
      check("split_l1", hs_log[b+1].len, 2);
    end
`else
    check("split_count", hs_log.size() - b, 1);
    if (hs_log.size() - b == 1) begin
      check("split_a0", hs_log[b].addr, 32'h0FC0);
      check("split_l0", hs_log[b].len, 3);
    end
`endif

    // Reset while a burst is waiting for memory
    mem_rd_ready = 1'b0;
    set_req(0, 32'h3000, 40, 1, 2);
    run(4);
    check("rst_pre_req", mem_rd_req, 1);
    reset = 1'b1;
    req_valid = '0;
    step();
    reset = 1'b0;
    check("rst_mid_req", mem_rd_req, 0);
    check("rst_mid_busy", busy, 0);
    mem_rd_ready = 1'b1;
    b = gnt_log.size();
    for (int i = 0; i < N; i++) set_req(i, 32'h5000 + 32'(i * 64), 1, i, 1);
    run(15);
    check("rst_first_grant", (gnt_log.size() > b) ? gnt_log[b] : 99, 0);

    // Randomized traffic, then drain
    rand_mode = 1;
    run(3000);
    rand_mode = 0;
    mem_rd_ready = 1'b1;
    read_info_full = 1'b0;
    run(400);
    check("drain_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
